// File: rtl/aes_spi_pkg.sv
// rtl/aes_spi_pkg.sv - shared types and widths for the AES SPI master
// Contents: FSM state enum, frame/block widths, bit-counter and phase-timer widths.
package aes_spi_pkg;

   localparam int FRAME_W = 256;   // {plaintext, key} shifted out MSB first
   localparam int BLOCK_W = 128;   // cyphertext read back
   localparam int CNT_W   = 9;     // bit counter, holds 0..256 without wrapping
   localparam int TMR_W   = 16;    // phase timer and done-timeout counter width

   typedef enum logic [3:0] {
      IDLE,
      SHIFT_LO,
      SHIFT_HI,
      RELEASE,
      WAIT_DONE,
      HOLD,
      READ_HI,
      READ_LO,
      FINISH
   } state_t;

endpackage

// File: rtl/spi_phase_timer.sv
// rtl/spi_phase_timer.sv - down-counter that times one sck half-period or hold phase
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load       : restart the phase; the phase then lasts count+1 cycles
//   count      : phase length minus one
//   tick       : high on the last cycle of the current phase
module spi_phase_timer
   import aes_spi_pkg::*;
#(
   parameter int W = TMR_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] count,
   output logic         tick
);

   logic [W-1:0] remaining;

   always_ff @(posedge clk) begin
      if (reset) begin
         remaining <= '0;
      end else if (load) begin
         remaining <= count;
      end else if (remaining != '0) begin
         remaining <= remaining - 1'b1;
      end
   end

   assign tick = (remaining == '0);

endmodule

// File: rtl/aes_spi_master.sv
// rtl/aes_spi_master.sv - SPI master that ships a block and key to an AES peripheral and reads the result
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : one-cycle request, taken only in IDLE
//   plaintext, key      : captured on an accepted start
//   cyphertext          : result, stable from valid until the next accepted start
//   busy, valid, error  : status; valid/error are one-cycle pulses
//   sck, sdi, load      : SPI clock, serial data out (MSB first), frame-load strobe
//   sdo, done           : serial result and result-ready flag from the peripheral
module aes_spi_master
   import aes_spi_pkg::*;
#(
   parameter int SCK_HALF  = 2,
   parameter int DONE_WAIT = 10,
   parameter int TIMEOUT   = 65535
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [BLOCK_W-1:0] plaintext,
   input  logic [BLOCK_W-1:0] key,
   output logic [BLOCK_W-1:0] cyphertext,
   output logic               busy,
   output logic               valid,
   output logic               error,
   output logic               sck,
   output logic               sdi,
   input  logic               sdo,
   output logic               load,
   input  logic               done
);

   localparam logic [TMR_W-1:0] HALF_LD = TMR_W'(SCK_HALF - 1);
   localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(DONE_WAIT - 1);
   localparam logic [TMR_W-1:0] TO_LIM  = TMR_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] LAST_WR = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(BLOCK_W - 1);

   state_t             state, next;
   logic               tmr_load, tick;
   logic [TMR_W-1:0]   tmr_val;
   logic [CNT_W-1:0]   bit_cnt;
   logic [TMR_W-1:0]   wait_cnt;
   logic [FRAME_W-1:0] frame;
   logic [BLOCK_W-1:0] rx;
   logic               accept;

   // The cycle carrying an error pulse is already IDLE; holding off start
   // there keeps a start coincident with error from being taken early.
   assign accept = (state == IDLE) && start && !error;
   assign sdi    = frame[FRAME_W-1];

   spi_phase_timer #(.W(TMR_W)) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (tmr_load),
      .count (tmr_val),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next;
      end
   end

   always_comb begin
      next     = state;
      tmr_load = 1'b0;
      tmr_val  = HALF_LD;
      sck      = 1'b0;
      load     = 1'b0;
      busy     = 1'b1;
      valid    = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (accept) begin
               next     = SHIFT_LO;
               tmr_load = 1'b1;
            end
         end
         SHIFT_LO: begin
            load = 1'b1;
            if (tick) begin
               next     = SHIFT_HI;
               tmr_load = 1'b1;
            end
         end
         SHIFT_HI: begin
            load = 1'b1;
            sck  = 1'b1;
            if (tick) begin
               next     = (bit_cnt == LAST_WR) ? RELEASE : SHIFT_LO;
               tmr_load = 1'b1;
            end
         end
         RELEASE: begin
            load = 1'b1;
            if (tick) next = WAIT_DONE;
         end
         WAIT_DONE: begin
            // wait_cnt is 0 only on the first cycle, the one right after load fell
            if (done && (wait_cnt != '0)) begin
               next     = HOLD;
               tmr_load = 1'b1;
               tmr_val  = HOLD_LD;
            end else if (wait_cnt == TO_LIM) begin
               next = IDLE;
            end
         end
         HOLD: begin
            if (tick) begin
               next     = READ_HI;
               tmr_load = 1'b1;
            end
         end
         READ_HI: begin
            sck = 1'b1;
            if (tick) begin
               next     = READ_LO;
               tmr_load = 1'b1;
            end
         end
         READ_LO: begin
            if (tick) begin
               next     = (bit_cnt == LAST_RD) ? FINISH : READ_HI;
               tmr_load = 1'b1;
            end
         end
         FINISH: begin
            busy  = 1'b0;
            valid = 1'b1;
            next  = IDLE;
         end
         default: begin
            next = IDLE;
            busy = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         frame      <= '0;
         rx         <= '0;
         cyphertext <= '0;
         bit_cnt    <= '0;
         wait_cnt   <= '0;
         error      <= 1'b0;
      end else begin
         error <= (state == WAIT_DONE) && (next == IDLE);
         case (state)
            IDLE: begin
               if (accept) begin
                  frame   <= {plaintext, key};
                  bit_cnt <= '0;
               end
            end
            SHIFT_HI: begin
               // shifting on the high-phase exit moves sdi only as sck falls
               if (tick) begin
                  frame   <= {frame[FRAME_W-2:0], 1'b0};
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            RELEASE:   wait_cnt <= '0;
            WAIT_DONE: wait_cnt <= wait_cnt + 1'b1;
            HOLD:      bit_cnt  <= '0;
            READ_HI: begin
               if (tick) rx <= {rx[BLOCK_W-2:0], sdo};
            end
            READ_LO: begin
               if (tick) begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == LAST_RD) cyphertext <= rx;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_spi_master.sv
// tb/tb_aes_spi_master.sv - self-checking bench: two masters (SCK_HALF 1 and 3) against a peripheral model
module tb_aes_spi_master;

   localparam int DW   = 4;
   localparam int TO   = 40;
   localparam int PDLY = 3;

   localparam logic [127:0] A1_KEY = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
   localparam logic [127:0] A1_PT  = 128'h3243F6A8885A308D313198A2E0370734;
   localparam logic [127:0] A1_CT  = 128'h3925841D02DC09FBDC118597196A0B32;
   localparam logic [127:0] C1_KEY = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899AABBCCDDEEFF;
   localparam logic [127:0] C1_CT  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

   logic         clk = 1'b0;
   logic         reset, start;
   logic [127:0] plaintext, key;
   logic [127:0] ct_l [2];
   logic         busy_l [2], valid_l [2], error_l [2], sck_l [2], sdi_l [2];
   logic         load_l [2], sdo_l [2], done_l [2];

   int           cyc = 0;
   int           pass_cnt = 0;
   int           tot_cnt = 0;
   bit           pending [2];
   int           wr_cnt [2];
   int           rd_cnt [2];
   int           vcount [2];
   logic [255:0] exp_frame [2];
   bit           no_done;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in for the AES core: known answers for the FIPS vectors, a keyed mix otherwise.
   function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [127:0] k);
      if (p == A1_PT && k == A1_KEY) return A1_CT;
      if (p == C1_PT && k == C1_KEY) return C1_CT;
      return p ^ {k[63:0], k[127:64]} ^ 128'h5A5A_C3C3_0F0F_9696_A5A5_3C3C_F0F0_6969;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input int lane, input string name, input logic [255:0] act, input logic [255:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL lane%0d %s: got %h required %h", lane, name, act, exp);
   endtask

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int SH      = (g == 0) ? 1 : 3;
      // start cycle -> pulse cycle: 1 + write(512*SH) + release(SH) + done delay + 1 + hold + read(256*SH)
      localparam int LAT_OK  = 2 + 769 * SH + PDLY + DW;
      localparam int LAT_ERR = 2 + 513 * SH + TO;

      aes_spi_master #(.SCK_HALF(SH), .DONE_WAIT(DW), .TIMEOUT(TO)) dut (
         .clk        (clk),
         .reset      (reset),
         .start      (start),
         .plaintext  (plaintext),
         .key        (key),
         .cyphertext (ct_l[g]),
         .busy       (busy_l[g]),
         .valid      (valid_l[g]),
         .error      (error_l[g]),
         .sck        (sck_l[g]),
         .sdi        (sdi_l[g]),
         .sdo        (sdo_l[g]),
         .load       (load_l[g]),
         .done       (done_l[g])
      );

      initial begin : lane_proc
         logic [255:0] frame_rx;
         logic [127:0] rd_word, model_ct, exp_val;
         bit           psck, pload, psdi, rd_active, last_reset, kind, wp, eb, ev, ee;
         int           dly, s_cyc, end_c;
         frame_rx = '0; rd_word = '0; model_ct = '0; exp_val = '0;
         psck = 0; pload = 0; psdi = 0; rd_active = 0; last_reset = 1; kind = 0;
         dly = 0; s_cyc = 0;
         pending[g] = 0; wr_cnt[g] = 0; rd_cnt[g] = 0; vcount[g] = 0;
         done_l[g] = 1'b0; sdo_l[g] = 1'b0;
         forever begin
            @(negedge clk);
            // peripheral
            if (reset) begin
               done_l[g] = 1'b0; sdo_l[g] = 1'b0;
               wr_cnt[g] = 0; rd_cnt[g] = 0; rd_active = 0; dly = 0;
               psck = 0; pload = 0; psdi = 0; frame_rx = '0;
            end else begin
               if (psck && sck_l[g]) chk(g, "sdi_stable_while_sck_high", sdi_l[g], psdi);
               if (sck_l[g] && !psck) begin
                  if (load_l[g]) begin
                     frame_rx = {frame_rx[254:0], sdi_l[g]};
                     wr_cnt[g]++;
                  end else begin
                     rd_cnt[g]++;
                     done_l[g] = 1'b0;
                  end
               end
               if (!sck_l[g] && psck && !load_l[g] && rd_active) begin
                  rd_word   = {rd_word[126:0], 1'b0};
                  sdo_l[g]  = rd_word[127];
               end
               if (pload && !load_l[g]) begin
                  chk(g, "write_edges", wr_cnt[g], 256);
                  chk(g, "frame_rx", frame_rx, exp_frame[g]);
                  wr_cnt[g] = 0;
                  rd_active = 0;
                  if (!no_done) dly = PDLY;
               end else if (dly > 0) begin
                  dly--;
                  if (dly == 0) begin
                     done_l[g] = 1'b1;
                     rd_word   = aes_ref(frame_rx[255:128], frame_rx[127:0]);
                     sdo_l[g]  = rd_word[127];
                     rd_cnt[g] = 0;
                     rd_active = 1;
                  end
               end
               psck = sck_l[g]; pload = load_l[g]; psdi = sdi_l[g];
            end
            // transaction model
            if (last_reset) begin
               pending[g] = 0;
               model_ct   = '0;
            end
            end_c = s_cyc + (kind ? LAT_ERR : LAT_OK);
            eb = pending[g] && (cyc > s_cyc) && (cyc < end_c);
            ev = pending[g] && !kind && (cyc == end_c);
            ee = pending[g] && kind && (cyc == end_c);
            if (ev) model_ct = exp_val;
            chk(g, "busy", busy_l[g], eb);
            chk(g, "valid", valid_l[g], ev);
            chk(g, "error", error_l[g], ee);
            chk(g, "cyphertext", ct_l[g], model_ct);
            if (!eb) begin
               chk(g, "sck_idle", sck_l[g], 0);
               chk(g, "load_idle", load_l[g], 0);
            end
            if (ev) chk(g, "read_edges", rd_cnt[g], 128);
            if (valid_l[g]) vcount[g]++;
            wp = pending[g];
            if (pending[g] && cyc == end_c) pending[g] = 0;
            if (!reset && start && !wp) begin
               pending[g]   = 1;
               s_cyc        = cyc;
               kind         = no_done;
               exp_val      = aes_ref(plaintext, key);
               exp_frame[g] = {plaintext, key};
            end
            last_reset = reset;
         end
      end
   end

   task automatic pulse_start(input logic [127:0] p, input logic [127:0] k);
      @(posedge clk); #1;
      plaintext = p; key = k; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; plaintext = rnd128(); key = rnd128();
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 6000; n++) begin
         @(posedge clk); #1;
         if (!pending[0] && !pending[1]) return;
      end
      tot_cnt++;
      $display("FAIL wait_idle: lanes still busy after 6000 cycles, required idle");
   endtask

   task automatic run(input logic [127:0] p, input logic [127:0] k);
      pulse_start(p, k);
      wait_idle();
   endtask

   initial begin
      bit found;
      reset = 1'b1; start = 1'b0; plaintext = '0; key = '0; no_done = 0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk(i, "reset_cyphertext", ct_l[i], '0);
         chk(i, "reset_busy", busy_l[i], 0);
         chk(i, "reset_valid", valid_l[i], 0);
         chk(i, "reset_error", error_l[i], 0);
         chk(i, "reset_sck", sck_l[i], 0);
         chk(i, "reset_sdi", sdi_l[i], 0);
         chk(i, "reset_load", load_l[i], 0);
      end
      reset = 1'b0;

      run(A1_PT, A1_KEY);
      for (int i = 0; i < 2; i++) chk(i, "fips_a1", ct_l[i], A1_CT);
      run(C1_PT, C1_KEY);
      for (int i = 0; i < 2; i++) chk(i, "fips_c1", ct_l[i], C1_CT);

      no_done = 1;
      run(rnd128(), rnd128());
      no_done = 0;
      for (int i = 0; i < 2; i++) chk(i, "timeout_keeps_ct", ct_l[i], C1_CT);

      repeat (3) run(rnd128(), rnd128());

      // start held through lane 0's valid cycle: taken only on the cycle after
      vcount[0] = 0; vcount[1] = 0;
      pulse_start(rnd128(), rnd128());
      found = 0;
      for (int n = 0; n < 3000 && !found; n++) begin
         @(posedge clk); #1;
         if (valid_l[0]) found = 1;
      end
      chk(0, "valid_seen", found, 1);
      plaintext = rnd128(); key = rnd128(); start = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle();
      chk(0, "restart_after_valid_count", vcount[0], 2);
      chk(1, "busy_ignores_start_count", vcount[1], 1);

      // start pulsed while lane 0 reads back
      vcount[0] = 0; vcount[1] = 0;
      pulse_start(rnd128(), rnd128());
      found = 0;
      for (int n = 0; n < 3000 && !found; n++) begin
         @(posedge clk); #1;
         if (rd_cnt[0] == 20) found = 1;
      end
      chk(0, "read_phase_reached", found, 1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle();
      chk(0, "start_in_read_valid_once", vcount[0], 1);
      chk(1, "start_in_write_valid_once", vcount[1], 1);

      // reset at write bit 100, then a full A.1 frame
      pulse_start(A1_PT, A1_KEY);
      found = 0;
      for (int n = 0; n < 3000 && !found; n++) begin
         @(posedge clk); #1;
         if (wr_cnt[0] == 100) found = 1;
      end
      chk(0, "write_bit_100_reached", found, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      run(A1_PT, A1_KEY);
      for (int i = 0; i < 2; i++) chk(i, "fips_a1_after_reset", ct_l[i], A1_CT);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule

// File: doc/aes_spi_master.md
AES_SPI_MASTER -- requirements
Module: aes_spi_master

Interface
REQ-001 Parameter SCK_HALF, 2, sck half-period in clk cycles (legal range 1..255).
REQ-002 Parameter DONE_WAIT, 10, clk cycles between done sampled high and the first read sck edge.
REQ-003 Parameter TIMEOUT, 65535, max clk cycles spent in WAIT_DONE before the operation aborts.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request; honoured only when busy=0.
REQ-007 plaintext  input  128  block to encrypt; captured on accepted start.
REQ-008 key  input  128  cipher key; captured on accepted start.
REQ-009 cyphertext  output  128  result; held stable from valid until the next accepted start.
REQ-010 busy  output  1  high from the cycle after accepted start until valid/error.
REQ-011 valid  output  1  one-cycle pulse: cyphertext updated.
REQ-012 error  output  1  one-cycle pulse: done timeout; cyphertext unchanged.
REQ-013 sck  output  1  SPI clock to the AES peripheral, idles low.
REQ-014 sdi  output  1  serial data to the peripheral, MSB first.
REQ-015 sdo  input  1  serial result from the peripheral.
REQ-016 load  output  1  high while the input frame is shifted in.
REQ-017 done  input  1  peripheral result-ready flag.

Function
REQ-018 States: IDLE, SHIFT_LO, SHIFT_HI, RELEASE, WAIT_DONE, HOLD, READ_HI, READ_LO, FINISH.
REQ-019 IDLE + start: latch frame = {plaintext, key} (256 b) and raise load and busy on the next cycle; bit counter=0; go to SHIFT_LO.
REQ-020 SHIFT_LO: sdi = frame[255-count] on state entry; sck=0 for SCK_HALF cycles; then go to SHIFT_HI.
REQ-021 SHIFT_HI: sck=1 for SCK_HALF cycles; sdi stable throughout; count increments on exit; exit to SHIFT_LO if count<256, else to RELEASE.
REQ-022 RELEASE: sck=0 for SCK_HALF cycles with load=1; then load=0; go to WAIT_DONE.
REQ-023 WAIT_DONE: done is ignored until load has been low for one cycle; done=1 moves to HOLD; a cycle counter reaching TIMEOUT raises error and returns to IDLE.
REQ-024 HOLD: wait DONE_WAIT cycles with sck=0; then count=0; go to READ_HI.
REQ-025 READ_HI: sck=1 for SCK_HALF cycles; sdo is sampled on the last clk cycle of the phase into cyphertext shift register bit [127-count].
REQ-026 READ_LO: sck=0 for SCK_HALF cycles; count increments; exit to READ_HI if count<128, else to FINISH.
REQ-027 FINISH: copy the shift register to cyphertext; assert valid for one cycle; busy=0; go to IDLE.
REQ-028 start while busy=1 is ignored with no effect on any output.
REQ-029 sdi changes only while sck=0; sck never toggles outside the SHIFT/RELEASE/READ states.
REQ-030 Frame length is exactly 256 write edges and 128 read edges; counters are 9 bits and never wrap.
REQ-031 start in the same cycle as valid/error is accepted only on the following cycle (in IDLE).

Reset
REQ-032 reset=1 at any point, including mid-frame: next state IDLE; sck=0, sdi=0, load=0, busy=0, valid=0, error=0, cyphertext=0, all counters=0.
REQ-033 reset has priority over start in the same cycle.

Structure
REQ-034 The shared package aes_spi_pkg SHALL hold the state enum, FRAME_W=256, BLOCK_W=128, and the counter width.
REQ-035 Half-period timing SHALL live in a sub-module spi_phase_timer (load, count, tick output).
REQ-036 Estimated size is 150-300 lines of RTL.

Verification
REQ-037 FIPS-197 A.1: key 2B7E151628AED2A6ABF7158809CF4F3C, pt 3243F6A8885A308D313198A2E0370734 -> valid once, cyphertext 3925841D02DC09FBDC118597196A0B32.
REQ-038 FIPS-197 C.1: key 000102030405060708090A0B0C0D0E0F, pt 00112233445566778899AABBCCDDEEFF -> cyphertext 69C4E0D86A7B0430D8CDB78070B4C55A.
REQ-039 Protocol check with SCK_HALF=1 and SCK_HALF=3: exactly 256 sck rising edges with load=1, then 128 with load=0; sdi is never changing while sck=1.
REQ-040 Peripheral model holding done=0: error pulses exactly TIMEOUT+1 cycles after WAIT_DONE entry; busy=0; cyphertext keeps its prior value.
REQ-041 reset asserted at write bit 100, then start -> full 256-bit frame restarts from bit 255; a correct A.1 result follows.
REQ-042 start pulsed during READ -> no effect; valid pulses exactly once.
